meta_chooser_q: RTL and testbench

Parametrised tournament chooser for the fetch stage. It selects between the local and global predictor outputs through a table of saturating chooser counters indexed by PC. Each fetch-time prediction is held in an in-flight queue until the branch resolves in ID. On resolution it trains the chooser, detects mispredicts, and drives a redirect and flush. It sits between the L/G predictors plus BTB and the PC-select mux.

---
 rtl/meta_pkg.sv | 27 ++
 rtl/meta_inflight_q.sv | 48 ++++
 rtl/meta_chooser_q.sv | 188 ++++++++++++++++++
 tb/tb_meta_chooser_q.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/meta_pkg.sv
// meta_pkg: shared types for the tournament chooser.
// Holds the in-flight entry layout, FSM states and counter init value.
package meta_pkg;

   localparam int META_IDX_W = 10;
   localparam int META_PC_W  = 32;

   typedef enum logic {
      INIT,
      RUN
   } meta_state_e;

   // One fetch-time prediction awaiting resolution in ID.
   typedef struct packed {
      logic [META_IDX_W-1:0] idx;
      logic                  pl;
      logic                  pg;
      logic                  fin;
      logic [META_PC_W-1:0]  target;
   } meta_entry_t;

   // Weakly-local: the largest value whose MSB is still clear.
   function automatic int ctr_init(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

endpackage

// File: rtl/meta_inflight_q.sv
// meta_inflight_q: circular FIFO of in-flight predictions.
// Ports: clk_i, rst_i (sync), push_i/data_i, pop_i, clear_i, head_o, count_o.
module meta_inflight_q
   import meta_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       clear_i,
   input  meta_entry_t                data_i,
   output meta_entry_t                head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);

   meta_entry_t   mem_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic [PW:0]   cnt_q;

   always_ff @(posedge clk_i) begin
      if (push_i && !clear_i && !rst_i) begin
         mem_q[wr_q] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + {{PW{1'b0}}, push_i}
                        - {{PW{1'b0}}, pop_i};
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/meta_chooser_q.sv
// meta_chooser_q: tournament chooser picking local vs global direction
// from PC-indexed saturating counters; tracks predictions until ID resolves.
// Ports: CLK, RESET (sync, active-high), STALL; IF_Valid/IF_PC,
// Pred_L/Pred_G, Hit_BTB/Alt_PC_BTB from fetch; ID_Valid/ID_PC/Is_Branch/
// Is_Taken/Alt_PC_ID from decode; Ready, Q_Full, Request_Alt_PC,
// Alt_Address, Flush out. Macro META_PERF_EN adds Branch_Count/Miss_Count.
module meta_chooser_q
   import meta_pkg::*;
#(
   parameter int IDX_W  = META_IDX_W,
   parameter int CTR_W  = 2,
   parameter int QDEPTH = 8,
   parameter int PC_W   = META_PC_W
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            STALL,
   input  logic            IF_Valid,
   input  logic [PC_W-1:0] IF_PC,
   input  logic            Pred_L,
   input  logic            Pred_G,
   input  logic            Hit_BTB,
   input  logic [PC_W-1:0] Alt_PC_BTB,
   input  logic            ID_Valid,
   input  logic [PC_W-1:0] ID_PC,
   input  logic            Is_Branch,
   input  logic            Is_Taken,
   input  logic [PC_W-1:0] Alt_PC_ID,
   output logic            Ready,
   output logic            Q_Full,
   output logic            Request_Alt_PC,
   output logic [PC_W-1:0] Alt_Address,
   output logic            Flush
`ifdef META_PERF_EN
   ,
   output logic [31:0]     Branch_Count,
   output logic [31:0]     Miss_Count
`endif
);

   localparam int NENT  = 1 << IDX_W;
   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_INI = CTR_W'(ctr_init(CTR_W));

   meta_state_e      state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic [CTR_W-1:0] tbl_q [NENT];
   logic             req_q, req_d;
   logic             flush_q, flush_d;
   logic [PC_W-1:0]  alt_q, alt_d;

   meta_entry_t      push_ent, head;
   logic [CNT_W-1:0] q_count;
   logic             q_full, q_empty;
   logic             run, push, resolve, mispred, train, dir_ok;
   logic [IDX_W-1:0] if_idx, h_idx;
   logic [CTR_W-1:0] if_ctr, h_ctr, h_ctr_nxt;
   logic             sel, fin;
   logic [PC_W-1:0]  tgt, h_tgt;

   assign run     = (state_q == RUN);
   assign q_full  = (q_count == CNT_W'(QDEPTH));
   assign q_empty = (q_count == '0);

   always_comb begin
      if_idx = IF_PC[IDX_W+1:2];
      if_ctr = tbl_q[if_idx];
      sel    = if_ctr[CTR_W-1] ? Pred_G : Pred_L;
      fin    = Hit_BTB & sel;
      tgt    = fin ? Alt_PC_BTB : IF_PC + PC_W'(4);
   end

   always_comb begin
      push_ent        = '0;
      push_ent.idx    = META_IDX_W'(if_idx);
      push_ent.pl     = Pred_L;
      push_ent.pg     = Pred_G;
      push_ent.fin    = fin;
      push_ent.target = META_PC_W'(tgt);
   end

   assign h_idx   = head.idx[IDX_W-1:0];
   assign h_tgt   = head.target[PC_W-1:0];
   assign resolve = run & ID_Valid & ~STALL & ~q_empty;
   assign mispred = resolve
                  & ((Is_Branch & ((Is_Taken != head.fin)
                                 | (Is_Taken & (Alt_PC_ID != h_tgt))))
                   | (~Is_Branch & head.fin));
   assign push    = run & IF_Valid & ~STALL & ~q_full & ~mispred;
   assign train   = resolve & Is_Branch & (head.pl != head.pg);

   always_comb begin
      h_ctr  = tbl_q[h_idx];
      dir_ok = (head.pg == Is_Taken);
      if (dir_ok) h_ctr_nxt = (h_ctr == CTR_MAX) ? h_ctr : h_ctr + 1'b1;
      else        h_ctr_nxt = (h_ctr == '0) ? h_ctr : h_ctr - 1'b1;
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      req_d   = req_q;
      alt_d   = alt_q;
      flush_d = flush_q;
      unique case (state_q)
         INIT: begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = RUN;
         end
         RUN: begin
            if (!STALL) begin
               flush_d = mispred;
               if (mispred) begin
                  req_d = 1'b1;
                  alt_d = (Is_Taken & Is_Branch) ? Alt_PC_ID
                                                 : ID_PC + PC_W'(8);
               end else begin
                  req_d = push & fin;
                  if (push) alt_d = tgt;
               end
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= INIT;
         sweep_q <= '0;
         req_q   <= 1'b0;
         alt_q   <= '0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         req_q   <= req_d;
         alt_q   <= alt_d;
         flush_q <= flush_d;
      end
   end

   // Reads above see the pre-write value on a same-index collision.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         if (state_q == INIT) tbl_q[sweep_q] <= CTR_INI;
         else if (train)      tbl_q[h_idx]   <= h_ctr_nxt;
      end
   end

   meta_inflight_q #(
      .DEPTH (QDEPTH)
   ) u_q (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .push_i  (push),
      .pop_i   (resolve & ~mispred),
      .clear_i (mispred),
      .data_i  (push_ent),
      .head_o  (head),
      .count_o (q_count)
   );

   assign Ready          = run;
   assign Q_Full         = q_full;
   assign Request_Alt_PC = req_q;
   assign Alt_Address    = alt_q;
   assign Flush          = flush_q;

`ifdef META_PERF_EN
   logic [31:0] bcnt_q, mcnt_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         bcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         if (resolve & Is_Branch) bcnt_q <= bcnt_q + 32'd1;
         if (mispred)             mcnt_q <= mcnt_q + 32'd1;
      end
   end

   assign Branch_Count = bcnt_q;
   assign Miss_Count   = mcnt_q;
`endif

endmodule

// File: tb/tb_meta_chooser_q.sv
// tb_meta_chooser_q: scoreboard bench for meta_chooser_q with a
// queue-based reference model, directed scenarios and random traffic.
module tb_meta_chooser_q;

   localparam int IDX_W  = 10;
   localparam int CTR_W  = 2;
   localparam int QDEPTH = 8;
   localparam int NENT   = 1 << IDX_W;
   localparam int CMAX   = (1 << CTR_W) - 1;

   logic        CLK = 1'b0;
   logic        RESET, STALL, IF_Valid, Pred_L, Pred_G, Hit_BTB;
   logic        ID_Valid, Is_Branch, Is_Taken;
   logic [31:0] IF_PC, Alt_PC_BTB, ID_PC, Alt_PC_ID;
   logic        Ready, Q_Full, Request_Alt_PC, Flush;
   logic [31:0] Alt_Address;
`ifdef META_PERF_EN
   logic [31:0] Branch_Count, Miss_Count;
`endif

   always #5 CLK = ~CLK;

   meta_chooser_q dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .STALL          (STALL),
      .IF_Valid       (IF_Valid),
      .IF_PC          (IF_PC),
      .Pred_L         (Pred_L),
      .Pred_G         (Pred_G),
      .Hit_BTB        (Hit_BTB),
      .Alt_PC_BTB     (Alt_PC_BTB),
      .ID_Valid       (ID_Valid),
      .ID_PC          (ID_PC),
      .Is_Branch      (Is_Branch),
      .Is_Taken       (Is_Taken),
      .Alt_PC_ID      (Alt_PC_ID),
      .Ready          (Ready),
      .Q_Full         (Q_Full),
      .Request_Alt_PC (Request_Alt_PC),
      .Alt_Address    (Alt_Address),
      .Flush          (Flush)
`ifdef META_PERF_EN
      ,
      .Branch_Count   (Branch_Count),
      .Miss_Count     (Miss_Count)
`endif
   );

   typedef struct {
      int          idx;
      bit          pl;
      bit          pg;
      bit          fin;
      logic [31:0] tgt;
   } ent_t;

   typedef struct {
      bit          rdy;
      bit          full;
      bit          req;
      bit          fl;
      logic [31:0] alt;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t        exp_q[$];
   ent_t        mq[$];
   int          mtab[NENT];
   bit          mrun;
   int          msweep;
   bit          mreq, mfl;
   logic [31:0] malt, mbc, mmc;
   int          checks = 0;
   int          errors = 0;
   exp_t        mon_e;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   // Reference: prediction from the pre-update table, then resolve,
   // train, and queue bookkeeping, all from the current inputs.
   function automatic exp_t model();
      exp_t        e;
      ent_t        h, n;
      bit          res, mis, full, sel, fin;
      int          ctr;
      logic [31:0] tgt;
      if (RESET) begin
         mrun = 0; msweep = 0; mq.delete();
         mreq = 0; mfl = 0; malt = 0; mbc = 0; mmc = 0;
      end else if (!mrun) begin
         mtab[msweep] = (1 << (CTR_W - 1)) - 1;
         msweep++;
         if (msweep == NENT) mrun = 1;
      end else if (!STALL) begin
         ctr  = mtab[int'(IF_PC[IDX_W+1:2])];
         sel  = (ctr >= (1 << (CTR_W - 1))) ? Pred_G : Pred_L;
         fin  = Hit_BTB && sel;
         tgt  = fin ? Alt_PC_BTB : IF_PC + 32'd4;
         full = (mq.size() == QDEPTH);
         res  = ID_Valid && (mq.size() > 0);
         mis  = 0;
         if (res) begin
            h = mq[0];
            if (Is_Branch) begin
               mbc++;
               mis = (Is_Taken != h.fin) || (Is_Taken && Alt_PC_ID != h.tgt);
               if (h.pl != h.pg) begin
                  if (Is_Taken == h.pg) begin
                     if (mtab[h.idx] < CMAX) mtab[h.idx]++;
                  end else begin
                     if (mtab[h.idx] > 0) mtab[h.idx]--;
                  end
               end
            end else begin
               mis = h.fin;
            end
         end
         if (mis) begin
            mmc++;
            mq.delete();
            mfl  = 1;
            mreq = 1;
            malt = (Is_Taken && Is_Branch) ? Alt_PC_ID : ID_PC + 32'd8;
         end else begin
            mfl = 0;
            if (res) void'(mq.pop_front());
            if (IF_Valid && !full) begin
               n.idx = int'(IF_PC[IDX_W+1:2]);
               n.pl  = Pred_L;
               n.pg  = Pred_G;
               n.fin = fin;
               n.tgt = tgt;
               mq.push_back(n);
               mreq = fin;
               malt = tgt;
            end else begin
               mreq = 0;
            end
         end
      end
      e.rdy  = mrun;
      e.full = (mq.size() == QDEPTH);
      e.req  = mreq;
      e.fl   = mfl;
      e.alt  = malt;
      e.bc   = mbc;
      e.mc   = mmc;
      return e;
   endfunction

   task automatic cyc();
      exp_t e;
      e = model();
      @(posedge CLK);
      exp_q.push_back(e);
      #1;
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         chk("Ready", 32'(Ready), 32'(mon_e.rdy));
         chk("Q_Full", 32'(Q_Full), 32'(mon_e.full));
         chk("Request_Alt_PC", 32'(Request_Alt_PC), 32'(mon_e.req));
         chk("Flush", 32'(Flush), 32'(mon_e.fl));
         chk("Alt_Address", Alt_Address, mon_e.alt);
`ifdef META_PERF_EN
         chk("Branch_Count", Branch_Count, mon_e.bc);
         chk("Miss_Count", Miss_Count, mon_e.mc);
`endif
      end
   end

   task automatic idle_inputs();
      STALL = 0; IF_Valid = 0; Pred_L = 0; Pred_G = 0; Hit_BTB = 0;
      ID_Valid = 0; Is_Branch = 0; Is_Taken = 0;
      IF_PC = 0; Alt_PC_BTB = 0; ID_PC = 0; Alt_PC_ID = 0;
   endtask

   task automatic check_table(input string n);
      for (int i = 0; i < NENT; i++)
         chk(n, 32'(dut.tbl_q[i]), 32'(mtab[i]));
   endtask

   initial begin
      idle_inputs();
      RESET = 1;
      cyc();
      RESET = 0;
      // Ready rises after exactly NENT sweep cycles.
      repeat (NENT - 1) cyc();
      chk("ready_before_sweep_end", 32'(Ready), 32'd0);
      cyc();
      chk("ready_after_sweep", 32'(Ready), 32'd1);
      check_table("tbl_init");

      // First prediction at 0x100 follows local (not taken).
      IF_Valid = 1; Hit_BTB = 1; Pred_L = 0; Pred_G = 1;
      IF_PC = 32'h100; Alt_PC_BTB = 32'h200;
      cyc();
      IF_Valid = 0;
      chk("p1_req", 32'(Request_Alt_PC), 32'd0);
      chk("p1_alt", Alt_Address, 32'h104);
      ID_Valid = 1; Is_Branch = 1; Is_Taken = 1;
      ID_PC = 32'h100; Alt_PC_ID = 32'h200;
      cyc();
      ID_Valid = 0;
      chk("p1_flush", 32'(Flush), 32'd1);
      chk("p1_redirect", Alt_Address, 32'h200);
      chk("p1_ctr", 32'(dut.tbl_q[32'h40]), 32'd2);

      // Now global is trusted; taken and correct twice -> saturate.
      for (int k = 0; k < 2; k++) begin
         IF_Valid = 1;
         cyc();
         IF_Valid = 0;
         chk("p2_req", 32'(Request_Alt_PC), 32'd1);
         chk("p2_alt", Alt_Address, 32'h200);
         ID_Valid = 1;
         cyc();
         ID_Valid = 0;
         chk("p2_noflush", 32'(Flush), 32'd0);
         chk("p2_ctr", 32'(dut.tbl_q[32'h40]), 32'd3);
      end

      // Fill the queue with fall-through predictions.
      Hit_BTB = 0; Pred_G = 0; IF_PC = 32'h180; IF_Valid = 1;
      repeat (QDEPTH) cyc();
      chk("full", 32'(Q_Full), 32'd1);
      cyc();
      chk("full_no_push_req", 32'(Request_Alt_PC), 32'd0);
      chk("full_count", 32'(dut.q_count), 32'd8);
      IF_Valid = 0; ID_Valid = 1; Is_Branch = 0;
      cyc();
      chk("pop_count", 32'(dut.q_count), 32'd7);
      IF_Valid = 1;
      cyc();
      chk("pushpop_count", 32'(dut.q_count), 32'd7);
      ID_Valid = 0;
      cyc();
      chk("refill_full", 32'(Q_Full), 32'd1);

      // Mispredict on a not-taken head clears everything.
      IF_Valid = 0; ID_Valid = 1; Is_Branch = 1; Is_Taken = 1;
      Alt_PC_ID = 32'h180;
      cyc();
      ID_Valid = 0;
      chk("clr_flush", 32'(Flush), 32'd1);
      chk("clr_count", 32'(dut.q_count), 32'd0);

      // Five taken predictions, then the head resolves not-taken.
      IF_PC = 32'h100; Hit_BTB = 1; Pred_L = 0; Pred_G = 1; IF_Valid = 1;
      repeat (5) cyc();
      chk("five_count", 32'(dut.q_count), 32'd5);
      IF_Valid = 0; ID_Valid = 1; Is_Branch = 1; Is_Taken = 0;
      ID_PC = 32'h300;
      cyc();
      ID_Valid = 0;
      chk("mp_flush", 32'(Flush), 32'd1);
      chk("mp_alt", Alt_Address, 32'h308);
      chk("mp_count", 32'(dut.q_count), 32'd0);
      cyc();
      chk("mp_flush_once", 32'(Flush), 32'd0);

      // Reset in the middle of the sweep restarts it.
      idle_inputs();
      RESET = 1;
      cyc();
      RESET = 0;
      repeat (7) cyc();
      RESET = 1;
      cyc();
      RESET = 0;
      repeat (NENT - 1) cyc();
      chk("resweep_low", 32'(Ready), 32'd0);
      cyc();
      chk("resweep_high", 32'(Ready), 32'd1);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         RESET      = ($urandom_range(0, 1499) == 0);
         STALL      = ($urandom_range(0, 9) == 0);
         IF_Valid   = ($urandom_range(0, 3) != 0);
         IF_PC      = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC
                    : 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
         Pred_L     = 1'($urandom_range(0, 1));
         Pred_G     = 1'($urandom_range(0, 1));
         Hit_BTB    = ($urandom_range(0, 3) != 0);
         Alt_PC_BTB = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
         ID_Valid   = ($urandom_range(0, 1) != 0);
         Is_Branch  = ($urandom_range(0, 4) != 0);
         Is_Taken   = 1'($urandom_range(0, 1));
         ID_PC      = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                    : 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
         if (mq.size() > 0 && $urandom_range(0, 2) != 0)
            Alt_PC_ID = mq[0].tgt;
         else
            Alt_PC_ID = 32'h1000 + 32'($urandom_range(0, 3)) * 32'd4;
         cyc();
      end
      idle_inputs();
      RESET = 0;
      cyc();
      @(negedge CLK);
      #1;
      check_table("tbl_final");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
